// File: rtl/flow_pkg.sv
// Shared width helpers for streaming blocks: slot-index width and packed output-word width.
package flow_pkg;

   // Counter width able to index n slots; at least one bit.
   function automatic int unsigned slot_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned word_w(input int unsigned n, input int unsigned w);
      return n * w;
   endfunction

endpackage

// File: rtl/combine.sv
// Packs N consecutive input words into one N*WDTH output word, first word in the LSBs.
// Optional COMBINE_FLUSH_EN adds a flush input that emits a partially filled word.
module combine
   import flow_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned LOG_N = slot_w(N),
   parameter int unsigned WDTH  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WDTH-1:0]            in_data,
   input  logic                       in_nd,
`ifdef COMBINE_FLUSH_EN
   input  logic                       flush,
`endif
   output logic [word_w(N, WDTH)-1:0] out_data,
   output logic                       out_nd
);

   localparam int unsigned      OUT_W = word_w(N, WDTH);
   localparam logic [LOG_N-1:0] LAST  = LOG_N'(N - 1);

   logic [LOG_N-1:0] r_cnt;
   logic [OUT_W-1:0] r_acc;
   logic [OUT_W-1:0] r_out;
   logic             r_nd;
   logic [OUT_W-1:0] w_acc_nxt;
   logic             w_emit;

   // Accumulator with this cycle's word merged into slot r_cnt.
   always_comb begin
      w_acc_nxt = r_acc;
      for (int unsigned k = 0; k < N; k++) begin
         if (in_nd && (r_cnt == LOG_N'(k))) begin
            w_acc_nxt[k*WDTH +: WDTH] = in_data;
         end
      end
   end

`ifdef COMBINE_FLUSH_EN
   // A flush emits whenever at least one slot holds data, including this cycle's word.
   assign w_emit = (in_nd && (r_cnt == LAST)) || (flush && (in_nd || (r_cnt != '0)));
`else
   assign w_emit = in_nd && (r_cnt == LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_acc <= '0;
         r_out <= '0;
         r_nd  <= 1'b0;
      end else begin
         r_nd <= w_emit;
         if (w_emit) begin
            r_out <= w_acc_nxt;
            r_acc <= '0;
            r_cnt <= '0;
         end else if (in_nd) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + LOG_N'(1);
         end
      end
   end

   assign out_data = r_out;
   assign out_nd   = r_nd;

endmodule

// File: tb/tb_combine.sv
// Directed bench for combine: N=2/WDTH=32 and N=4/WDTH=8 instances side by side.
// Flush sequences run only when COMBINE_FLUSH_EN is defined.
module tb_combine;

   typedef struct {
      logic        nd;
      logic [7:0]  data;
      logic        exp_nd;
      logic [31:0] exp_data;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] d2_data;
   logic        d2_nd;
   logic [63:0] d2_out;
   logic        d2_ond;
   logic [7:0]  d4_data;
   logic        d4_nd;
   logic [31:0] d4_out;
   logic        d4_ond;
`ifdef COMBINE_FLUSH_EN
   logic        d2_flush;
   logic        d4_flush;
`endif

   int n_vec;
   int n_err;
   vec_t tbl[14];

   combine #(.N(2), .LOG_N(1), .WDTH(32)) u_dut2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (d2_data),
      .in_nd    (d2_nd),
`ifdef COMBINE_FLUSH_EN
      .flush    (d2_flush),
`endif
      .out_data (d2_out),
      .out_nd   (d2_ond)
   );

   combine #(.N(4), .LOG_N(2), .WDTH(8)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (d4_data),
      .in_nd    (d4_nd),
`ifdef COMBINE_FLUSH_EN
      .flush    (d4_flush),
`endif
      .out_data (d4_out),
      .out_nd   (d4_ond)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic nd, input logic [7:0] data,
                          input logic exp_nd, input logic [31:0] exp_data);
      tbl[i].nd       = nd;
      tbl[i].data     = data;
      tbl[i].exp_nd   = exp_nd;
      tbl[i].exp_data = exp_data;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      // back-to-back 0x01..0x0C on the N=4 instance, then two idle cycles
      set_vec(0,  1'b1, 8'h01, 1'b0, 32'h0000_0000);
      set_vec(1,  1'b1, 8'h02, 1'b0, 32'h0000_0000);
      set_vec(2,  1'b1, 8'h03, 1'b0, 32'h0000_0000);
      set_vec(3,  1'b1, 8'h04, 1'b1, 32'h0403_0201);
      set_vec(4,  1'b1, 8'h05, 1'b0, 32'h0403_0201);
      set_vec(5,  1'b1, 8'h06, 1'b0, 32'h0403_0201);
      set_vec(6,  1'b1, 8'h07, 1'b0, 32'h0403_0201);
      set_vec(7,  1'b1, 8'h08, 1'b1, 32'h0807_0605);
      set_vec(8,  1'b1, 8'h09, 1'b0, 32'h0807_0605);
      set_vec(9,  1'b1, 8'h0A, 1'b0, 32'h0807_0605);
      set_vec(10, 1'b1, 8'h0B, 1'b0, 32'h0807_0605);
      set_vec(11, 1'b1, 8'h0C, 1'b1, 32'h0C0B_0A09);
      set_vec(12, 1'b0, 8'hFF, 1'b0, 32'h0C0B_0A09);
      set_vec(13, 1'b0, 8'h00, 1'b0, 32'h0C0B_0A09);

      rst_n   = 1'b1;
      d2_data = '0;
      d2_nd   = 1'b0;
      d4_data = '0;
      d4_nd   = 1'b0;
`ifdef COMBINE_FLUSH_EN
      d2_flush = 1'b0;
      d4_flush = 1'b0;
`endif
      #2 rst_n = 1'b0;
      tick();
      tick();
      check("reset d2 out_nd",   64'(d2_ond), 64'd0);
      check("reset d2 out_data", d2_out,      64'd0);
      check("reset d4 out_nd",   64'(d4_ond), 64'd0);
      check("reset d4 out_data", 64'(d4_out), 64'd0);
      #3 rst_n = 1'b1;
      tick();

      // two words on consecutive cycles
      d2_data = 32'h1111_1111; d2_nd = 1'b1;
      tick();
      check("pair first out_nd", 64'(d2_ond), 64'd0);
      d2_data = 32'h2222_2222;
      tick();
      check("pair out_nd",   64'(d2_ond), 64'd1);
      check("pair out_data", d2_out,      64'h2222_2222_1111_1111);
      d2_nd = 1'b0; d2_data = 32'hDEAD_BEEF;
      tick();
      check("pair pulse width", 64'(d2_ond), 64'd0);
      check("pair hold data",   d2_out,      64'h2222_2222_1111_1111);

      // gap of five idle cycles between the two halves
      d2_data = 32'h0000_000A; d2_nd = 1'b1;
      tick();
      d2_nd = 1'b0; d2_data = 32'h5555_5555;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("gap idle %0d out_nd", i), 64'(d2_ond), 64'd0);
      end
      d2_data = 32'h0000_000B; d2_nd = 1'b1;
      tick();
      check("gap out_nd",   64'(d2_ond), 64'd1);
      check("gap out_data", d2_out,      64'h0000_000B_0000_000A);
      d2_nd = 1'b0;

      // table-driven N=4 stream
      for (int i = 0; i < 14; i++) begin
         d4_nd   = tbl[i].nd;
         d4_data = tbl[i].data;
         tick();
         check($sformatf("tbl[%0d] out_nd", i),   64'(d4_ond), 64'(tbl[i].exp_nd));
         check($sformatf("tbl[%0d] out_data", i), 64'(d4_out), 64'(tbl[i].exp_data));
      end

      // partial word discarded by a mid-cycle reset
      d4_nd = 1'b1; d4_data = 8'hEE;
      tick();
      d4_data = 8'hFF;
      tick();
      d4_nd = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async reset d4 out_data", 64'(d4_out), 64'd0);
      check("async reset d4 out_nd",   64'(d4_ond), 64'd0);
      check("async reset d2 out_data", d2_out,      64'd0);
      tick();
      #3 rst_n = 1'b1;
      tick();
      d4_nd = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         d4_data = 8'(i);
         tick();
         check($sformatf("post reset word %0d out_nd", i), 64'(d4_ond), (i == 4) ? 64'd1 : 64'd0);
      end
      check("post reset out_data", 64'(d4_out), 64'h0403_0201);
      d4_nd = 1'b0;
      tick();
      check("post reset pulse width", 64'(d4_ond), 64'd0);

`ifdef COMBINE_FLUSH_EN
      // flush of a two-word partial, then a flush with nothing stored
      d4_nd = 1'b1; d4_data = 8'hAA;
      tick();
      d4_data = 8'hBB;
      tick();
      d4_nd = 1'b0; d4_flush = 1'b1;
      tick();
      check("flush partial out_nd",   64'(d4_ond), 64'd1);
      check("flush partial out_data", 64'(d4_out), 64'h0000_BBAA);
      tick();
      check("flush empty out_nd",   64'(d4_ond), 64'd0);
      check("flush empty out_data", 64'(d4_out), 64'h0000_BBAA);
      d4_flush = 1'b0;
      tick();

      // flush coinciding with the completing word gives one output
      d2_nd = 1'b1; d2_data = 32'h1;
      tick();
      d2_data = 32'h2; d2_flush = 1'b1;
      tick();
      check("flush complete out_nd",   64'(d2_ond), 64'd1);
      check("flush complete out_data", d2_out,      64'h0000_0002_0000_0001);
      d2_nd = 1'b0; d2_flush = 1'b0;
      tick();
      check("flush complete single", 64'(d2_ond), 64'd0);
      tick();
      check("flush complete quiet", 64'(d2_ond), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/combine.md
COMBINE -- requirements
Module: combine

Interface
REQ-001 Parameter: N, default 2, number of consecutive input words packed into one output word (N >= 2).
REQ-002 Parameter: LOG_N, default 1, counter width, ceil(log2(N)).
REQ-003 Parameter: WDTH, default 32, width of one input word.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: in_data  input  WDTH  input sample word.
REQ-007 Port: in_nd  input  1  in_data valid this cycle; no backpressure.
REQ-008 Port: out_data  output  N*WDTH  packed word; slot k = bits [(k+1)*WDTH-1 : k*WDTH].
REQ-009 Port: out_nd  output  1  single-cycle pulse, out_data valid.
REQ-010 Port: flush  input  1  present only when COMBINE_FLUSH_EN is defined; see REQ-022.

Function
REQ-011 Block SHALL hold a slot counter cnt (LOG_N bits, range 0..N-1) and an accumulation register acc (N*WDTH bits).
REQ-012 On in_nd=1, in_data SHALL be written to slot cnt of acc and cnt SHALL advance by 1.
REQ-013 The first word after reset or after an emitted word SHALL land in slot 0 (LSBs); the Nth word in slot N-1.
REQ-014 When in_nd=1 and cnt=N-1, cnt SHALL wrap to 0 and the completed word (including this cycle's in_data) SHALL be loaded into the output register.
REQ-015 Latency: out_nd SHALL be 1 exactly one cycle after the cycle carrying the Nth word, and 0 in every other cycle.
REQ-016 out_data SHALL be a separate registered copy, stable from one out_nd pulse until the next, unaffected by further filling of acc.
REQ-017 Cycles with in_nd=0 SHALL not change cnt or acc; gaps of any length between input words are permitted.
REQ-018 Back-to-back inputs (in_nd=1 every cycle) SHALL produce one out_nd every N cycles with no lost word.
REQ-019 After a word is emitted, acc slots SHALL be cleared to 0 so stale data never appears in a later output.
REQ-020 The block SHALL not reorder, duplicate or drop input words.

Reset
REQ-021 While rst_n=0 (asynchronously on assertion): cnt=0, acc=0, out_data=0, out_nd=0; a partially filled word SHALL be discarded; the first in_nd after rst_n deasserts SHALL land in slot 0.

Configuration
REQ-022 With COMBINE_FLUSH_EN defined: a flush=1 cycle SHALL emit the current partial word next cycle (out_nd=1, unfilled slots 0) and reset cnt to 0.
REQ-023 Flush and in_nd in the same cycle: in_data SHALL be stored first, then the result flushed; if this completes the word, exactly one output SHALL occur.
REQ-024 Flush with cnt=0 and in_nd=0 SHALL produce no output.
REQ-025 Without COMBINE_FLUSH_EN: no flush port, no flush logic; behaviour exactly REQ-011..REQ-021.

Structure
REQ-026 Shared package (flow_pkg) SHALL hold the slot-index helper/width constant and the output-word width expression N*WDTH; no typedefs local to the block.
REQ-027 Block SHALL be a single module with no sub-modules; the counter and slot decoder are inline.

Verification
REQ-028 N=2, WDTH=32: in 0x11111111 then 0x22222222 on consecutive cycles -> one cycle after second, out_nd=1, out_data=0x22222222_11111111.
REQ-029 N=4, WDTH=8: 12 back-to-back words 0x01..0x0C -> out_nd pulses every 4 cycles with 0x04030201, 0x08070605, 0x0C0B0A09; out_data stable between pulses.
REQ-030 N=2: 0xA, 5 idle cycles, 0xB -> single output 0x0000000B_0000000A; no out_nd during gap.
REQ-031 N=4: 2 words loaded, rst_n pulsed low mid-cycle -> outputs 0 immediately; next 4 words 0x1..0x4 -> 0x04030201 (old partial discarded).
REQ-032 COMBINE_FLUSH_EN, N=4, WDTH=8: words 0xAA, 0xBB then flush -> next cycle out_nd=1, out_data=0x0000BBAA; following flush with no data -> no out_nd.
REQ-033 COMBINE_FLUSH_EN, N=2: word 0x1 then word 0x2 with flush in same cycle -> exactly one out_nd, out_data=0x00000002_00000001.
